// File: rtl/aq_gemac_tx_arb_if.sv
// Frame-write port shared by the two TX sources and the MAC TX buffer.
// master drives a frame into the port; slave accepts it and owns gnt/full/ready.
interface aq_gemac_tx_arb_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic        start;
    logic        last;
    logic [31:0] data;
    logic        full;
    logic        ready;

    modport master (
        output req, we, start, last, data,
        input  gnt, full, ready
    );

    modport slave (
        input  req, we, start, last, data,
        output gnt, full, ready
    );
endinterface

// File: rtl/aq_gemac_tx_arb.sv
// Whole-frame arbiter for the aq_gemac TX buffer write port, with stall watchdog and frame counters.
// Define AQ_GEMAC_TX_ARB_PRIO_EN for fixed priority to port A instead of round-robin.
module aq_gemac_tx_arb #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    aq_gemac_tx_arb_if.slave       a,
    aq_gemac_tx_arb_if.slave       b,
    aq_gemac_tx_arb_if.master      tx,
    output logic                   timeout_pulse,
    output logic                   timeout_port,
    output logic [CNT_W-1:0]       a_frames,
    output logic [CNT_W-1:0]       b_frames
);

    localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StGrantA, StGrantB, StGap} state_e;

    state_e           state_q;
    logic             gnt_a_q, gnt_b_q, ptr_b_q, to_port_q;
    logic [WdW-1:0]   wd_q;
    logic [CNT_W-1:0] a_cnt_q, b_cnt_q;

    logic        granted, sel_b, pick_b;
    logic        src_we, src_start, src_last;
    logic [31:0] src_data;
    logic        accept, done, abort;
    logic        unused_tx_gnt;

    assign granted   = (state_q == StGrantA) || (state_q == StGrantB);
    assign sel_b     = (state_q == StGrantB);
    assign src_we    = sel_b ? b.we    : a.we;
    assign src_start = sel_b ? b.start : a.start;
    assign src_last  = sel_b ? b.last  : a.last;
    assign src_data  = sel_b ? b.data  : a.data;

    assign accept = granted && src_we && !tx.full;
    assign done   = accept && src_last;
    // Abort fires on the TIMEOUT-th consecutive idle cycle; an accepted word (incl. END) always wins.
    assign abort  = granted && !accept && !rst && (TIMEOUT != 0) &&
                    (wd_q == WdW'(TIMEOUT - 1));

`ifdef AQ_GEMAC_TX_ARB_PRIO_EN
    logic unused_ptr_b;
    assign unused_ptr_b = ptr_b_q;
    assign pick_b       = !a.req;
`else
    assign pick_b = b.req && (!a.req || ptr_b_q);
`endif

    assign tx.req   = granted;
    assign tx.we    = accept;
    assign tx.start = granted && src_we && src_start;
    assign tx.last  = (granted && src_we && src_last) || abort;
    assign tx.data  = granted ? src_data : 32'h0;

    assign a.gnt   = gnt_a_q;
    assign b.gnt   = gnt_b_q;
    assign a.full  = (state_q != StGrantA) || tx.full;
    assign b.full  = (state_q != StGrantB) || tx.full;
    assign a.ready = tx.ready;
    assign b.ready = tx.ready;

    assign timeout_pulse = abort;
    assign timeout_port  = abort ? sel_b : to_port_q;
    assign a_frames      = a_cnt_q;
    assign b_frames      = b_cnt_q;
    assign unused_tx_gnt = tx.gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            ptr_b_q   <= 1'b0;
            to_port_q <= 1'b0;
            wd_q      <= '0;
            a_cnt_q   <= '0;
            b_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tx.ready && (a.req || b.req)) begin
                        state_q <= pick_b ? StGrantB : StGrantA;
                        gnt_a_q <= !pick_b;
                        gnt_b_q <= pick_b;
                        wd_q    <= '0;
                    end
                end
                StGrantA, StGrantB: begin
                    if (done || abort) begin
                        state_q <= StGap;
                        gnt_a_q <= 1'b0;
                        gnt_b_q <= 1'b0;
                        ptr_b_q <= !sel_b;
                        if (done && sel_b)  b_cnt_q <= b_cnt_q + CNT_W'(1);
                        if (done && !sel_b) a_cnt_q <= a_cnt_q + CNT_W'(1);
                        if (abort)          to_port_q <= sel_b;
                    end else if (accept) begin
                        wd_q <= '0;
                    end else if (TIMEOUT != 0) begin
                        wd_q <= wd_q + WdW'(1);
                    end
                end
                StGap:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aq_gemac_tx_arb.sv
// Bench for aq_gemac_tx_arb: directed scenarios plus a randomized phase, all checked
// cycle by cycle against an ownership-level reference model.
module tb_aq_gemac_tx_arb;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 4;
`ifdef AQ_GEMAC_TX_ARB_PRIO_EN
    localparam bit Prio = 1'b1;
`else
    localparam bit Prio = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          tp, tport;
    logic [CW-1:0] a_frames, b_frames;

    aq_gemac_tx_arb_if a_if ();
    aq_gemac_tx_arb_if b_if ();
    aq_gemac_tx_arb_if tx_if ();

    aq_gemac_tx_arb #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .a             (a_if),
        .b             (b_if),
        .tx            (tx_if),
        .timeout_pulse (tp),
        .timeout_port  (tport),
        .a_frames      (a_frames),
        .b_frames      (b_frames)
    );

    always #5 clk = ~clk;

    // Stimulus values applied each cycle.
    logic        req [2], we [2], st [2], ls [2];
    logic [31:0] dat [2];
    logic        full, ready, srst;

    // Reference model: who owns the buffer and the bookkeeping around it.
    int owner = -1;
    bit gap, rr_b;
    int idle;
    int frames [2];
    int last_to;
    bit m_acc, m_ab;

    // Random source state and knobs.
    bit auto_en, rnd_rst;
    bit act [2], stl [2];
    int idx [2], len [2];
    int k_act, k_we, k_stall, k_full, k_ready, k_lmin, k_lmax, k_drop;

    int checks, errors, cyc;
    bit chk_en;
    int pulses, pulse_cyc, pulse_port;
    bit a_prev, b_prev;
    logic [31:0] tx_log [$];
    int gnt_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic void drive();
        rst         = srst;
        a_if.req    = req[0];  a_if.we = we[0];  a_if.start = st[0];
        a_if.last   = ls[0];   a_if.data = dat[0];
        b_if.req    = req[1];  b_if.we = we[1];  b_if.start = st[1];
        b_if.last   = ls[1];   b_if.data = dat[1];
        tx_if.full  = full;
        tx_if.ready = ready;
        tx_if.gnt   = 1'b1;
    endfunction

    function automatic void new_frame(input int p);
        idx[p] = 0;
        len[p] = int'($urandom_range(k_lmax, k_lmin));
        stl[p] = ($urandom_range(99) < k_stall);
        act[p] = ($urandom_range(99) < k_act);
    endfunction

    function automatic void plan();
        for (int p = 0; p < 2; p++) begin
            if (owner == p) begin
                req[p] = ($urandom_range(99) >= k_drop);
                we[p]  = !(stl[p] && idx[p] > 0) && ($urandom_range(99) < k_we);
                st[p]  = (idx[p] == 0);
                ls[p]  = (idx[p] == len[p] - 1);
            end else begin
                req[p] = act[p];
                we[p]  = 1'($urandom_range(1));
                st[p]  = 1'($urandom_range(1));
                ls[p]  = 1'($urandom_range(1));
            end
            dat[p] = $urandom;
        end
        full  = ($urandom_range(99) < k_full);
        ready = ($urandom_range(99) < k_ready);
        srst  = rnd_rst && ($urandom_range(299) == 0);
    endfunction

    function automatic void src_post(input int prev);
        for (int p = 0; p < 2; p++) begin
            if (srst) idx[p] = 0;
            else if (prev == p && m_acc && ls[p] === 1'b1) new_frame(p);
            else if (prev == p && m_acc) idx[p]++;
            else if (prev == p && m_ab) new_frame(p);
            else if (!act[p]) act[p] = ($urandom_range(99) < k_act);
        end
    endfunction

    function automatic void model_step();
        if (srst) begin
            owner = -1; gap = 0; rr_b = 0; idle = 0;
            frames[0] = 0; frames[1] = 0; last_to = 0;
        end else if (owner >= 0) begin
            if (m_acc && ls[owner] === 1'b1) begin
                frames[owner] = (frames[owner] + 1) % (1 << CW);
                rr_b = (owner == 0); owner = -1; gap = 1;
            end else if (m_ab) begin
                last_to = owner; rr_b = (owner == 0); owner = -1; gap = 1;
            end else begin
                idle = m_acc ? 0 : idle + 1;
            end
        end else if (gap) begin
            gap = 0;
        end else if (ready && (req[0] || req[1])) begin
            if (req[0] && req[1]) owner = Prio ? 0 : int'(rr_b);
            else owner = req[0] ? 0 : 1;
            idle = 0;
        end
    endfunction

    task automatic cycle();
        bit own;
        int o, prev;
        @(negedge clk);
        if (auto_en) plan();
        drive();
        #1;
        own   = (owner >= 0);
        o     = own ? owner : 0;
        m_acc = own && we[o] && !full;
        m_ab  = own && !srst && (TO != 0) && (idle == TO - 1) && !m_acc;
        if (chk_en) begin
            check("a_gnt",    32'(a_if.gnt),  32'(owner == 0));
            check("b_gnt",    32'(b_if.gnt),  32'(owner == 1));
            check("a_full",   32'(a_if.full), 32'(owner == 0 ? full : 1'b1));
            check("b_full",   32'(b_if.full), 32'(owner == 1 ? full : 1'b1));
            check("tx_we",    32'(tx_if.we),    32'(m_acc));
            check("tx_start", 32'(tx_if.start), 32'(own && we[o] && st[o]));
            check("tx_end",   32'(tx_if.last),  32'((own && we[o] && ls[o]) || m_ab));
            check("tx_data",  tx_if.data, own ? dat[o] : 32'h0);
            check("to_pulse", 32'(tp),    32'(m_ab));
            check("to_port",  32'(tport), 32'(m_ab ? o : last_to));
            check("a_frames", 32'(a_frames), 32'(frames[0]));
            check("b_frames", 32'(b_frames), 32'(frames[1]));
        end
        if (tx_if.we === 1'b1) tx_log.push_back(tx_if.data);
        if (tp === 1'b1) begin
            pulses++; pulse_cyc = cyc; pulse_port = int'(tport);
        end
        if (a_if.gnt === 1'b1 && !a_prev) gnt_log.push_back(0);
        if (b_if.gnt === 1'b1 && !b_prev) gnt_log.push_back(1);
        a_prev = (a_if.gnt === 1'b1);
        b_prev = (b_if.gnt === 1'b1);
        @(posedge clk);
        prev = owner;
        model_step();
        if (auto_en) src_post(prev);
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; st[p] = 1'b0; ls[p] = 1'b0; dat[p] = 32'h0;
        end
        full = 1'b0; ready = 1'b1; srst = 1'b0; auto_en = 1'b0; rnd_rst = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        srst = 1'b1;
        cycle();
        srst = 1'b0;
        tx_log.delete();
        gnt_log.delete();
        pulses = 0;
    endtask

    // One frame from port p; fpat bit g forces TX_BUFF_FULL on the g-th granted cycle.
    task automatic send(input int p, input int n, input logic [31:0] base,
                        input logic [31:0] step, input logic [31:0] fpat);
        int i = 0;
        int g = 0;
        bit mine;
        req[p] = 1'b1;
        for (int k = 0; k < 100 && i < n; k++) begin
            mine = (owner == p);
            if (mine) begin
                req[p] = 1'b0;
                we[p]  = 1'b1;
                st[p]  = (i == 0);
                ls[p]  = (i == n - 1);
                dat[p] = base + step * 32'(i);
                full   = (g < 32) ? fpat[g] : 1'b0;
                g++;
            end else begin
                we[p] = 1'b0; st[p] = 1'b0; ls[p] = 1'b0; dat[p] = 32'h0; full = 1'b0;
            end
            cycle();
            if (mine && m_acc) i++;
        end
        req[p] = 1'b0; we[p] = 1'b0; st[p] = 1'b0; ls[p] = 1'b0; dat[p] = 32'h0; full = 1'b0;
        check("send_words", 32'(i), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int wcyc;
        chk_en = 1'b0;
        do_reset();
        chk_en = 1'b1;
        cycle();

        // Single A frame of four words.
        send(0, 4, 32'h11111111, 32'h11111111, 32'h0);
        cycle();
        check("t1_len", 32'(tx_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < tx_log.size(); i++)
            check("t1_word", tx_log[i], 32'h11111111 * 32'(i + 1));
        check("t1_frames", 32'(a_frames), 32'd1);
        check("t1_gnt_drop", 32'(a_if.gnt), 32'd0);

        // Both ports contend for four frames.
        do_reset();
        k_act = 100; k_we = 100; k_stall = 0; k_full = 0; k_ready = 100;
        k_lmin = 3; k_lmax = 3; k_drop = 0;
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b1; stl[p] = 1'b0; idx[p] = 0; len[p] = 3;
        end
        auto_en = 1'b1;
        for (int k = 0; k < 200 && gnt_log.size() < 4; k++) cycle();
        clear_inputs();
        check("t2_grants", 32'(gnt_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
            check("t2_order", 32'((i < gnt_log.size()) ? gnt_log[i] : 99),
                  32'(Prio ? 0 : i % 2));

        // B frame with a three-cycle buffer stall mid-frame.
        do_reset();
        send(1, 5, 32'hB0000000, 32'h1, 32'h0000001C);
        cycle();
        check("t3_len", 32'(tx_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < tx_log.size(); i++)
            check("t3_word", tx_log[i], 32'hB0000000 + 32'(i));
        check("t3_frames", 32'(b_frames), 32'd1);

        // A stalls after its START word; B waits behind it.
        do_reset();
        req[0] = 1'b1; req[1] = 1'b1;
        for (int k = 0; k < 10 && owner != 0; k++) cycle();
        req[0] = 1'b0; we[0] = 1'b1; st[0] = 1'b1; dat[0] = 32'hA0A0A0A0;
        wcyc = cyc;
        cycle();
        we[0] = 1'b0; st[0] = 1'b0; dat[0] = 32'h0;
        for (int k = 0; k < 30 && b_if.gnt !== 1'b1; k++) cycle();
        check("t4_pulses", 32'(pulses), 32'd1);
        check("t4_delay", 32'(pulse_cyc - wcyc), 32'(TO));
        check("t4_port", 32'(pulse_port), 32'd0);
        check("t4_a_frames", 32'(a_frames), 32'd0);
        check("t4_b_gnt", 32'(b_if.gnt), 32'd1);

        // READY low blocks grants; reset mid-frame.
        do_reset();
        ready = 1'b0; req[0] = 1'b1; req[1] = 1'b1;
        repeat (5) cycle();
        check("t5_hold", 32'({a_if.gnt, b_if.gnt}), 32'd0);
        ready = 1'b1;
        cycle();
        check("t5_grant", 32'(a_if.gnt), 32'd1);
        req[0] = 1'b0; req[1] = 1'b0;
        we[0] = 1'b1; st[0] = 1'b1; dat[0] = 32'h5A5A5A5A;
        cycle();
        srst = 1'b1;
        cycle();
        srst = 1'b0;
        check("t5_rst_gnt", 32'({a_if.gnt, b_if.gnt}), 32'd0);
        check("t5_rst_full", 32'({a_if.full, b_if.full}), 32'd3);
        check("t5_rst_tx", 32'({tx_if.we, tx_if.start, tx_if.last}), 32'd0);
        clear_inputs();
        cycle();

        // Counter wrap.
        do_reset();
        for (int f = 0; f < 16; f++) send(0, 1, 32'hC000 + 32'(f), 32'h0, 32'h0);
        cycle();
        check("t5_wrap0", 32'(a_frames), 32'd0);
        send(0, 1, 32'hC0FF, 32'h0, 32'h0);
        cycle();
        check("t5_wrap1", 32'(a_frames), 32'd1);

        // Randomized traffic.
        do_reset();
        k_act = 30; k_we = 75; k_stall = 10; k_full = 20; k_ready = 85;
        k_lmin = 1; k_lmax = 6; k_drop = 20;
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; stl[p] = 1'b0; idx[p] = 0; len[p] = 1;
        end
        auto_en = 1'b1; rnd_rst = 1'b1;
        repeat (3000) cycle();
        clear_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
